// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Round-robin sharing of one data-memory port between the core load/store
// unit (port 0) and debug/DMA (port 1). Load metadata is queued in an
// in-order tracking FIFO and replayed to memory_receive when data returns,
// together with the id of the requester that should take the result.
module memory_port_arbiter #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int NUM_BYTES      = DATA_WIDTH / 8,
    parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    // requester 0: core load/store unit
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic                          req0_read,
    input  logic [ADDRESS_BITS-1:0]       req0_address,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic [LOG2_NUM_BYTES-1:0]     req0_log2_bytes,
    input  logic                          req0_unsigned,
    // requester 1: debug / DMA
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic                          req1_read,
    input  logic [ADDRESS_BITS-1:0]       req1_address,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    input  logic [LOG2_NUM_BYTES-1:0]     req1_log2_bytes,
    input  logic                          req1_unsigned,
    // memory command
    output logic                          mem_valid,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDRESS_BITS-1:0]       mem_address,
    output logic [DATA_WIDTH-1:0]         mem_data_out,
    input  logic                          mem_ready,
    // memory response (in order)
    input  logic                          mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_resp_data,
    // memory_receive formatter inputs
    output logic [LOG2_NUM_BYTES-1:0]     rx_log2_bytes,
    output logic                          rx_unsigned_load,
    output logic [DATA_WIDTH-1:0]         rx_memory_data,
    output logic [DATA_WIDTH-1:0]         rx_memory_address,
    // response steering and status
    output logic                          resp0_valid,
    output logic                          resp1_valid,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding,
    output logic                          resp_error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + LOG2_NUM_BYTES + 1 + LOG2_NUM_BYTES;

    // CORE only names the instance for debug; nothing to build for bad values.
    if (CORE < 0 || FIFO_DEPTH < 2) begin : g_param_guard
    end

    logic                      prio_reg;
    logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic                      resp0_valid_reg, resp1_valid_reg, resp_error_reg;
    logic [LOG2_NUM_BYTES-1:0] rx_log2_bytes_reg;
    logic                      rx_unsigned_reg;
    logic [DATA_WIDTH-1:0]     rx_data_reg;
    logic [LOG2_NUM_BYTES-1:0] rx_addr_low_reg;

    logic                      grant;
    logic                      g_read, g_unsigned;
    logic [ADDRESS_BITS-1:0]   g_address;
    logic [DATA_WIDTH-1:0]     g_data;
    logic [LOG2_NUM_BYTES-1:0] g_log2_bytes;
    logic                      full, empty, handshake, push, pop;
    logic [1:0]                ready_vec;
    logic [ENTRY_W-1:0]        push_entry, head_entry;

    // Grant: a lone requester wins outright, otherwise the priority pointer decides.
    always_comb begin
        grant = prio_reg;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end

    assign g_read       = grant ? req1_read       : req0_read;
    assign g_unsigned   = grant ? req1_unsigned   : req0_unsigned;
    assign g_address    = grant ? req1_address    : req0_address;
    assign g_data       = grant ? req1_data       : req0_data;
    assign g_log2_bytes = grant ? req1_log2_bytes : req0_log2_bytes;

    assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty = (count_reg == '0);

    // A load with no tracking slot is held back; stores never need one.
    assign mem_valid    = !reset && (req0_valid || req1_valid) && !(g_read && full);
    assign mem_read     = mem_valid && g_read;
    assign mem_write    = mem_valid && !g_read;
    assign mem_address  = g_address;
    assign mem_data_out = g_data;
    assign handshake    = mem_valid && mem_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = handshake && (grant == 1'(gi));
    end
    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // full already excludes accepted loads, so a pop can never make room for a same-cycle push
    assign push       = handshake && g_read;
    assign pop        = mem_resp_valid && !empty;
    assign push_entry = {grant, g_log2_bytes, g_unsigned, g_address[LOG2_NUM_BYTES-1:0]};
    assign head_entry = fifo_mem[rd_ptr_reg];

    // Tracking storage: written at the tail on every accepted load.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Arbitration pointer, FIFO bookkeeping and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_reg          <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            resp0_valid_reg   <= 1'b0;
            resp1_valid_reg   <= 1'b0;
            resp_error_reg    <= 1'b0;
            rx_log2_bytes_reg <= '0;
            rx_unsigned_reg   <= 1'b0;
            rx_data_reg       <= '0;
            rx_addr_low_reg   <= '0;
        end else begin
            if (handshake) begin
                prio_reg <= ~grant;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            resp0_valid_reg <= pop && !head_entry[ENTRY_W-1];
            resp1_valid_reg <= pop &&  head_entry[ENTRY_W-1];
            if (mem_resp_valid && empty) begin
                resp_error_reg <= 1'b1;
            end
            if (pop) begin
                rx_data_reg       <= mem_resp_data;
                rx_log2_bytes_reg <= head_entry[ENTRY_W-2 -: LOG2_NUM_BYTES];
                rx_unsigned_reg   <= head_entry[LOG2_NUM_BYTES];
                rx_addr_low_reg   <= head_entry[LOG2_NUM_BYTES-1:0];
            end
        end
    end

    assign resp0_valid       = resp0_valid_reg;
    assign resp1_valid       = resp1_valid_reg;
    assign resp_error        = resp_error_reg;
    assign outstanding       = count_reg;
    assign rx_log2_bytes     = rx_log2_bytes_reg;
    assign rx_unsigned_load  = rx_unsigned_reg;
    assign rx_memory_data    = rx_data_reg;
    assign rx_memory_address = {{(DATA_WIDTH-LOG2_NUM_BYTES){1'b0}}, rx_addr_low_reg};

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: reset, lone load, contention,
// full tracking FIFO, ordering/steering, spurious response, reset mid-traffic.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_read, req0_unsigned;
    logic [19:0] req0_address;
    logic [31:0] req0_data;
    logic [1:0]  req0_log2_bytes;
    logic        req1_valid, req1_ready, req1_read, req1_unsigned;
    logic [19:0] req1_address;
    logic [31:0] req1_data;
    logic [1:0]  req1_log2_bytes;
    logic        mem_valid, mem_read, mem_write, mem_ready;
    logic [19:0] mem_address;
    logic [31:0] mem_data_out;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [1:0]  rx_log2_bytes;
    logic        rx_unsigned_load;
    logic [31:0] rx_memory_data, rx_memory_address;
    logic        resp0_valid, resp1_valid, resp_error;
    logic [2:0]  outstanding;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    memory_port_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_read(req0_read),
        .req0_address(req0_address), .req0_data(req0_data),
        .req0_log2_bytes(req0_log2_bytes), .req0_unsigned(req0_unsigned),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_read(req1_read),
        .req1_address(req1_address), .req1_data(req1_data),
        .req1_log2_bytes(req1_log2_bytes), .req1_unsigned(req1_unsigned),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .rx_log2_bytes(rx_log2_bytes), .rx_unsigned_load(rx_unsigned_load),
        .rx_memory_data(rx_memory_data), .rx_memory_address(rx_memory_address),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .outstanding(outstanding), .resp_error(resp_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // advance one clock; inputs are then changed and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_read = 0; req0_unsigned = 0; req0_address = '0; req0_data = '0; req0_log2_bytes = '0;
        req1_valid = 0; req1_read = 0; req1_unsigned = 0; req1_address = '0; req1_data = '0; req1_log2_bytes = '0;
        mem_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        step(); step();

        // ---- reset state; command path held off while reset is high
        req0_valid = 1; req0_read = 1; mem_ready = 1;
        #1;
        check_eq("rst_mem_valid", 32'(mem_valid), 0);
        check_eq("rst_req0_ready", 32'(req0_ready), 0);
        check_eq("rst_outstanding", 32'(outstanding), 0);
        check_eq("rst_resp_error", 32'(resp_error), 0);
        check_eq("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 0);
        check_eq("rst_rx_data", rx_memory_data, 0);
        check_eq("rst_rx_addr", rx_memory_address, 0);
        req0_valid = 0;
        step();
        reset = 0;

        // ---- lone load: LW 0x104
        req0_valid = 1; req0_read = 1; req0_address = 20'h00104; req0_log2_bytes = 2; req0_unsigned = 0;
        #1;
        check_eq("lw_mem_valid", 32'(mem_valid), 1);
        check_eq("lw_req0_ready", 32'(req0_ready), 1);
        check_eq("lw_mem_read", 32'(mem_read), 1);
        check_eq("lw_mem_address", 32'(mem_address), 32'h104);
        step();
        req0_valid = 0;
        check_eq("lw_outstanding1", 32'(outstanding), 1);
        step(); step();
        mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
        step();
        mem_resp_valid = 0;
        check_eq("lw_resp0_valid", 32'(resp0_valid), 1);
        check_eq("lw_resp1_valid", 32'(resp1_valid), 0);
        check_eq("lw_rx_data", rx_memory_data, 32'hDEADBEEF);
        check_eq("lw_rx_log2", 32'(rx_log2_bytes), 2);
        check_eq("lw_rx_unsigned", 32'(rx_unsigned_load), 0);
        check_eq("lw_rx_addr", rx_memory_address, 0);
        check_eq("lw_outstanding0", 32'(outstanding), 0);
        step();
        check_eq("lw_resp0_pulse", 32'(resp0_valid), 0);
        check_eq("lw_rx_hold", rx_memory_data, 32'hDEADBEEF);

        // ---- lone store from req1 (moves the pointer back to requester 0)
        req1_valid = 1; req1_read = 0; req1_address = 20'h00200; req1_data = 32'h22222222;
        #1;
        check_eq("st1_req1_ready", 32'(req1_ready), 1);
        check_eq("st1_mem_write", 32'(mem_write), 1);
        check_eq("st1_mem_data", mem_data_out, 32'h22222222);
        step();

        // ---- contention: both stores valid; grants alternate 0,1,0,1
        req0_valid = 1; req0_read = 0; req0_address = 20'h00100; req0_data = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("cont%0d_req0_ready", i), 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("cont%0d_req1_ready", i), 32'(req1_ready), (i % 2 == 0) ? 0 : 1);
            check_eq($sformatf("cont%0d_addr", i), 32'(mem_address), (i % 2 == 0) ? 32'h100 : 32'h200);
            step();
        end
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("stall%0d_mem_valid", i), 32'(mem_valid), 1);
            check_eq($sformatf("stall%0d_ready", i), 32'({req1_ready, req0_ready}), 0);
            check_eq($sformatf("stall%0d_addr", i), 32'(mem_address), 32'h100);
            step();
        end
        mem_ready = 1;
        #1;
        check_eq("stall_release_req0", 32'(req0_ready), 1);
        step();
        req0_valid = 0; req1_valid = 0;

        // ---- full FIFO: four loads from req0 back to back
        req0_valid = 1; req0_read = 1; req0_log2_bytes = 2; req0_unsigned = 0;
        for (int k = 0; k < 4; k++) begin
            req0_address = 20'h00020 + 20'(k);
            #1;
            check_eq($sformatf("fill%0d_req0_ready", k), 32'(req0_ready), 1);
            step();
        end
        req0_address = 20'h00027;
        #1;
        check_eq("full_outstanding", 32'(outstanding), 4);
        check_eq("full_mem_valid", 32'(mem_valid), 0);
        check_eq("full_req0_ready", 32'(req0_ready), 0);
        req1_valid = 1; req1_read = 0; req1_address = 20'h00030; req1_data = 32'h55;
        #1;
        check_eq("full_store_ready", 32'(req1_ready), 1);
        check_eq("full_store_write", 32'(mem_write), 1);
        check_eq("full_store_addr", 32'(mem_address), 32'h30);
        check_eq("full_load_blocked", 32'(req0_ready), 0);
        step();
        req1_valid = 0;
        #1;
        check_eq("full_load_mem_valid", 32'(mem_valid), 0);
        mem_resp_valid = 1; mem_resp_data = 32'hA0;
        #1;
        check_eq("full_pop_no_bypass", 32'(mem_valid), 0);
        step();
        mem_resp_valid = 0;
        check_eq("full_pop_outstanding", 32'(outstanding), 3);
        check_eq("full_pop_resp0", 32'(resp0_valid), 1);
        check_eq("full_pop_rx_data", rx_memory_data, 32'hA0);
        check_eq("full_pop_rx_addr", rx_memory_address, 0);
        check_eq("full_admit_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 0;
        check_eq("refill_outstanding", 32'(outstanding), 4);
        for (int k = 1; k <= 4; k++) begin
            mem_resp_valid = 1; mem_resp_data = 32'hA0 + 32'(k);
            step();
            check_eq($sformatf("drain%0d_resp0", k), 32'(resp0_valid), 1);
            check_eq($sformatf("drain%0d_rx_data", k), rx_memory_data, 32'hA0 + 32'(k));
            check_eq($sformatf("drain%0d_rx_addr", k), rx_memory_address, (k < 4) ? 32'(k) : 32'd3);
            check_eq($sformatf("drain%0d_outstanding", k), 32'(outstanding), 32'(4 - k));
        end
        mem_resp_valid = 0;
        step();
        check_eq("drain_done_resp0", 32'(resp0_valid), 0);

        // ---- ordering / steering: req0 LBU 0x3 then req1 LH 0x2
        req0_valid = 1; req0_read = 1; req0_address = 20'h00003; req0_log2_bytes = 0; req0_unsigned = 1;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_read = 1; req1_address = 20'h00002; req1_log2_bytes = 1; req1_unsigned = 0;
        #1;
        check_eq("ord_req1_ready", 32'(req1_ready), 1);
        step();
        req1_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h80000000;
        step();
        mem_resp_data = 32'h00FF0000;
        check_eq("ord1_resp", 32'({resp1_valid, resp0_valid}), 32'b01);
        check_eq("ord1_rx_data", rx_memory_data, 32'h80000000);
        check_eq("ord1_rx_addr", rx_memory_address, 3);
        check_eq("ord1_unsigned", 32'(rx_unsigned_load), 1);
        check_eq("ord1_log2", 32'(rx_log2_bytes), 0);
        step();
        mem_resp_valid = 0;
        check_eq("ord2_resp", 32'({resp1_valid, resp0_valid}), 32'b10);
        check_eq("ord2_rx_data", rx_memory_data, 32'h00FF0000);
        check_eq("ord2_rx_addr", rx_memory_address, 2);
        check_eq("ord2_unsigned", 32'(rx_unsigned_load), 0);
        check_eq("ord2_log2", 32'(rx_log2_bytes), 1);
        step();
        check_eq("ord_idle_resp", 32'({resp1_valid, resp0_valid}), 0);

        // ---- spurious response with empty FIFO
        mem_resp_valid = 1; mem_resp_data = 32'h12345678;
        step();
        mem_resp_valid = 0;
        check_eq("spur_resp", 32'({resp1_valid, resp0_valid}), 0);
        check_eq("spur_error", 32'(resp_error), 1);
        check_eq("spur_outstanding", 32'(outstanding), 0);
        check_eq("spur_rx_data_held", rx_memory_data, 32'h00FF0000);
        step(); step();
        check_eq("spur_error_sticky", 32'(resp_error), 1);

        // ---- reset mid-operation with two loads outstanding
        req0_valid = 1; req0_read = 1; req0_address = 20'h00040; req0_log2_bytes = 2; req0_unsigned = 0;
        step(); step();
        check_eq("mid_outstanding", 32'(outstanding), 2);
        reset = 1;
        #1;
        check_eq("mid_rst_mem_valid", 32'(mem_valid), 0);
        check_eq("mid_rst_req0_ready", 32'(req0_ready), 0);
        step();
        reset = 0; req0_valid = 0;
        check_eq("mid_post_outstanding", 32'(outstanding), 0);
        check_eq("mid_post_error", 32'(resp_error), 0);
        check_eq("mid_post_rx_data", rx_memory_data, 0);
        req0_valid = 1; req0_read = 0; req1_valid = 1; req1_read = 0;
        #1;
        check_eq("mid_prio_req0", 32'(req0_ready), 1);
        check_eq("mid_prio_req1", 32'(req1_ready), 0);
        step();
        req0_valid = 0; req1_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
        step();
        mem_resp_valid = 0;
        check_eq("stale_error", 32'(resp_error), 1);
        check_eq("stale_resp", 32'({resp1_valid, resp0_valid}), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one data-memory port between two requesters (port 0: core load/store unit, port 1: debug/DMA) using round-robin arbitration. Records per-load formatting metadata in an in-order tracking FIFO. When memory data returns, it drives the `memory_receive` formatter inputs and steers the response to the requester that issued the load. It sits between the core's memory issue stage, the data memory, and `memory_receive`.

## Interface
- `CORE`, 0, core index (debug only)
- `DATA_WIDTH`, 32, data bus width
- `ADDRESS_BITS`, 20, memory address width
- `NUM_BYTES`, DATA_WIDTH/8, bytes per word
- `LOG2_NUM_BYTES`, log2(NUM_BYTES), access-size field width
- `FIFO_DEPTH`, 4, max outstanding loads; power of two, ≥2
- `clock` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `reqN_valid` in 1 (N=0,1): request present
- `reqN_ready` out 1: request accepted this cycle
- `reqN_read` in 1: 1=load, 0=store
- `reqN_address` in ADDRESS_BITS: byte address
- `reqN_data` in DATA_WIDTH: store data
- `reqN_log2_bytes` in LOG2_NUM_BYTES: access size
- `reqN_unsigned` in 1: zero-extend load
- `mem_valid`, `mem_read`, `mem_write` out 1: memory command
- `mem_address` out ADDRESS_BITS; `mem_data_out` out DATA_WIDTH
- `mem_ready` in 1: memory accepts command
- `mem_resp_valid` in 1; `mem_resp_data` in DATA_WIDTH: load data, returned in order
- `rx_log2_bytes` out LOG2_NUM_BYTES; `rx_unsigned_load` out 1; `rx_memory_data` out DATA_WIDTH; `rx_memory_address` out DATA_WIDTH: feed `memory_receive`
- `respN_valid` out 1: formatted load data (`memory_receive.load_data`) belongs to requester N this cycle
- `outstanding` out log2(FIFO_DEPTH)+1: loads in flight
- `resp_error` out 1: sticky; response arrived with FIFO empty

## Operation
- Grant (combinational):
  - Only one `reqN_valid` → that requester.
  - Both valid → requester named by priority pointer `prio`.
- `mem_valid` = any `reqN_valid` & !(granted is load & FIFO full). `mem_*` fields are muxed from the granted requester. `mem_valid` never depends on `mem_ready`.
- Handshake `H` = `mem_valid & mem_ready`. `reqN_ready` = `H` & granted==N. Non-granted `reqN_ready` = 0.
- On `H`: `prio` ← the non-granted requester.
- Requesters hold valid and payload stable until ready.
- Loads on `H` push {id, log2_bytes, unsigned, address[LOG2_NUM_BYTES-1:0]}. Stores push nothing and produce no response.
- Push is blocked when full, even if a pop occurs in the same cycle (no bypass). Push and pop in the same cycle when not full: `outstanding` is unchanged.
- `mem_resp_valid` with FIFO non-empty pops the head and registers:
  - `rx_memory_data` ← `mem_resp_data`
  - `rx_log2_bytes`, `rx_unsigned_load` ← head fields
  - `rx_memory_address` ← zero-extended low bits
  - `resp{id}_valid` ← 1
- `mem_resp_valid` with FIFO empty: ignored, `resp_error` ← 1 (cleared only by reset).
- FIFO pointers wrap modulo FIFO_DEPTH. `outstanding` never exceeds FIFO_DEPTH and never underflows.

## Timing
- Request path is combinational: accepted in the same cycle `mem_ready` is sampled high.
- Response latency: `respN_valid` and `rx_*` are valid exactly 1 cycle after `mem_resp_valid`. `respN_valid` is a 1-cycle pulse per response; `rx_*` hold until the next response.
- Back-to-back responses every cycle are supported. Back-to-back grants every cycle are supported.
- Reset (any cycle, including mid-traffic) forces on the next edge:
  - `prio`=0, FIFO empty, `outstanding`=0
  - `respN_valid`=0, all `rx_*`=0, `resp_error`=0
- In-flight loads are discarded on reset. The memory must be reset alongside this block; a stale response after reset sets `resp_error`.
- Outputs during reset cycle: `reqN_ready`=0 and `mem_valid`=0 while `reset` is high.

## Test plan
- Lone load: req0 LW addr 0x104, mem_ready=1; respond 0xDEADBEEF 3 cycles later → resp0_valid pulse 1 cycle after, rx_log2_bytes=2, rx_unsigned_load=0, rx_memory_address=0; `outstanding` 1→0.
- Contention: both valid continuously, mem_ready=1 → grants alternate 0,1,0,1. With mem_ready=0 for 3 cycles, the grant and `prio` hold.
- Full FIFO: 4 loads with no responses → `mem_valid`=0 for a 5th load while a store from req1 is still granted and accepted. A pop in the same cycle does not admit the blocked load until the next cycle.
- Ordering/steering: loads req0 LBU addr 0x3, req1 LH addr 0x2; responses 0x80000000, 0x00FF0000 → resp0_valid then resp1_valid, rx_address 3 then 2, unsigned 1 then 0.
- Spurious response: mem_resp_valid with FIFO empty → no respN_valid, `resp_error`=1 and sticky until reset.
- Reset mid-operation: 2 loads outstanding, assert reset 1 cycle → `outstanding`=0, prio=0. A subsequent response sets `resp_error`.
